// File: rtl/serial_loader.sv
// ============================================================================
// Module   : serial_loader
// Function : oversampling start/data/stop serial receiver feeding a load register
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_loader #(
  parameter int WIDTH        = 8,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic             clk,
  input  logic             async_nreset,
  input  logic             rx,
  input  logic             enable,
  output logic [WIDTH-1:0] data_out,
  output logic             load,
  output logic             frame_error,
  output logic             busy
);

  localparam int c_CNT_W = $clog2(CLKS_PER_BIT);
  localparam int c_IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [c_CNT_W-1:0] c_CNT_MID  = c_CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_START = 2'd1,
    S_DATA  = 2'd2,
    S_STOP  = 2'd3
  } state_t;

  state_t             r_state, w_state_nxt;
  logic               r_rx_meta, r_rx_s;
  logic [c_CNT_W-1:0] r_cnt, w_cnt_nxt;
  logic [c_IDX_W-1:0] r_idx, w_idx_nxt;
  logic [WIDTH-1:0]   r_shift, w_shift_nxt;
  logic [WIDTH-1:0]   r_data, w_data_nxt;
  logic               r_load, w_load_nxt;
  logic               r_ferr, w_ferr_nxt;

  // Line idles high, so the synchronizer resets to 1 to avoid a false start.
  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      r_rx_meta <= 1'b1;
      r_rx_s    <= 1'b1;
    end else begin
      r_rx_meta <= rx;
      r_rx_s    <= r_rx_meta;
    end
  end

  always_ff @(posedge clk or negedge async_nreset) begin
    if (!async_nreset) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_data  <= '0;
      r_load  <= 1'b0;
      r_ferr  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_idx   <= w_idx_nxt;
      r_shift <= w_shift_nxt;
      r_data  <= w_data_nxt;
      r_load  <= w_load_nxt;
      r_ferr  <= w_ferr_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + c_CNT_W'(1);
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_load_nxt  = 1'b0;
    w_ferr_nxt  = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (enable && !r_rx_s) begin
          w_state_nxt = S_START;
        end
      end
      S_START: begin
        if (r_cnt == c_CNT_MID) begin
          w_cnt_nxt   = '0;
          w_idx_nxt   = '0;
          w_state_nxt = r_rx_s ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (r_cnt == c_CNT_LAST) begin
          w_cnt_nxt   = '0;
          w_shift_nxt = {r_rx_s, r_shift[WIDTH-1:1]};
          if (r_idx == c_IDX_LAST) begin
            w_state_nxt = S_STOP;
          end else begin
            w_idx_nxt = r_idx + c_IDX_W'(1);
          end
        end
      end
      S_STOP: begin
        if (r_cnt == c_CNT_LAST) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
          if (r_rx_s) begin
            w_data_nxt = r_shift;
            w_load_nxt = 1'b1;
          end else begin
            w_ferr_nxt = 1'b1;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign data_out    = r_data;
  assign load        = r_load;
  assign frame_error = r_ferr;
  assign busy        = (r_state != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_serial_loader.sv
// Self-checking bench for serial_loader: frames are driven on rx and the
// observed pulses are compared with cycle times derived from the bit timing.
`timescale 1ns/1ps
`default_nettype none

module tb_serial_loader;

  localparam int W   = 8;
  localparam int CPB = 16;

  logic         clk = 1'b0;
  logic         async_nreset;
  logic         rx;
  logic         enable;
  logic [W-1:0] data_out;
  logic         load;
  logic         frame_error;
  logic         busy;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int           load_cyc[$];
  logic [W-1:0] load_dat[$];
  int           ferr_cyc[$];
  int           busy_rise[$];
  int           busy_cnt   = 0;
  int           rule_viol  = 0;
  logic         prev_pulse = 1'b0;
  logic         prev_busy  = 1'b0;

  serial_loader #(.WIDTH(W), .CLKS_PER_BIT(CPB)) dut (
    .clk         (clk),
    .async_nreset(async_nreset),
    .rx          (rx),
    .enable      (enable),
    .data_out    (data_out),
    .load        (load),
    .frame_error (frame_error),
    .busy        (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (load) begin
      load_cyc.push_back(cyc);
      load_dat.push_back(data_out);
    end
    if (frame_error) ferr_cyc.push_back(cyc);
    if (load && frame_error) rule_viol++;
    if ((load || frame_error) && prev_pulse) rule_viol++;
    prev_pulse = load || frame_error;
    if (busy) busy_cnt++;
    if (busy && !prev_busy) busy_rise.push_back(cyc);
    prev_busy = busy;
  end

  // rx changes in cycle s; two synchronizer stages, half a bit to the start
  // midpoint, WIDTH+1 full bits to the stop sample, then one registered cycle.
  function automatic int exp_pulse(input int s);
    return s + 2 + CPB / 2 + (W + 1) * CPB + 1;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [W-1:0] b, input logic stop_bit, output int s);
    rx = 1'b0;
    s  = cyc;
    idle(CPB);
    for (int i = 0; i < W; i++) begin
      rx = b[i];
      idle(CPB);
    end
    rx = stop_bit;
    idle(CPB);
  endtask

  task automatic test_reset();
    int n0;
    n0 = load_cyc.size() + ferr_cyc.size();
    idle(40);
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL reset_data got=%h exp=00", data_out); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    total++; if (busy_cnt !== 0) begin bad++; $display("FAIL reset_busy_seen got=%0d exp=0", busy_cnt); end
    total++; if (load_cyc.size() + ferr_cyc.size() - n0 !== 0) begin bad++; $display("FAIL reset_pulses got=%0d exp=0", load_cyc.size() + ferr_cyc.size() - n0); end
  endtask

  task automatic test_good_frame();
    int s, n0, f0;
    n0 = load_cyc.size(); f0 = ferr_cyc.size();
    enable = 1'b1;
    send_frame(8'hA5, 1'b1, s);
    rx = 1'b1;
    idle(20);
    total++;
    if (load_cyc.size() - n0 !== 1) begin
      bad++; $display("FAIL good_load_count got=%0d exp=1", load_cyc.size() - n0);
    end else begin
      total++; if (load_cyc[n0] !== exp_pulse(s)) begin bad++; $display("FAIL good_load_cycle got=%0d exp=%0d", load_cyc[n0], exp_pulse(s)); end
      total++; if (load_dat[n0] !== 8'hA5) begin bad++; $display("FAIL good_load_data got=%h exp=a5", load_dat[n0]); end
    end
    total++; if (ferr_cyc.size() - f0 !== 0) begin bad++; $display("FAIL good_ferr got=%0d exp=0", ferr_cyc.size() - f0); end
    total++; if (data_out !== 8'hA5) begin bad++; $display("FAIL good_hold got=%h exp=a5", data_out); end
  endtask

  task automatic test_frame_error();
    int s, n0, f0;
    n0 = load_cyc.size(); f0 = ferr_cyc.size();
    send_frame(8'h3C, 1'b0, s);
    rx = 1'b1;
    idle(3 * CPB);
    total++;
    if (ferr_cyc.size() - f0 !== 1) begin
      bad++; $display("FAIL ferr_count got=%0d exp=1", ferr_cyc.size() - f0);
    end else begin
      total++; if (ferr_cyc[f0] !== exp_pulse(s)) begin bad++; $display("FAIL ferr_cycle got=%0d exp=%0d", ferr_cyc[f0], exp_pulse(s)); end
    end
    total++; if (load_cyc.size() - n0 !== 0) begin bad++; $display("FAIL ferr_no_load got=%0d exp=0", load_cyc.size() - n0); end
    total++; if (data_out !== 8'hA5) begin bad++; $display("FAIL ferr_hold got=%h exp=a5", data_out); end
  endtask

  task automatic test_glitch();
    int s, b0, r0, p0;
    b0 = busy_cnt; r0 = busy_rise.size(); p0 = load_cyc.size() + ferr_cyc.size();
    rx = 1'b0;
    s  = cyc;
    idle(4);
    rx = 1'b1;
    idle(30);
    total++; if (busy_cnt - b0 !== CPB / 2) begin bad++; $display("FAIL glitch_busy_len got=%0d exp=%0d", busy_cnt - b0, CPB / 2); end
    total++;
    if (busy_rise.size() - r0 !== 1) begin
      bad++; $display("FAIL glitch_busy_rises got=%0d exp=1", busy_rise.size() - r0);
    end else begin
      total++; if (busy_rise[r0] !== s + 3) begin bad++; $display("FAIL glitch_busy_start got=%0d exp=%0d", busy_rise[r0], s + 3); end
    end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL glitch_busy_end got=%b exp=0", busy); end
    total++; if (load_cyc.size() + ferr_cyc.size() - p0 !== 0) begin bad++; $display("FAIL glitch_pulses got=%0d exp=0", load_cyc.size() + ferr_cyc.size() - p0); end
  endtask

  task automatic test_enable();
    int s, b0, n0, f0;
    b0 = busy_cnt; n0 = load_cyc.size(); f0 = ferr_cyc.size();
    enable = 1'b0;
    send_frame(8'h55, 1'b1, s);
    rx = 1'b1;
    idle(20);
    total++; if (busy_cnt - b0 !== 0) begin bad++; $display("FAIL en_off_busy got=%0d exp=0", busy_cnt - b0); end
    total++; if (load_cyc.size() + ferr_cyc.size() - n0 - f0 !== 0) begin bad++; $display("FAIL en_off_pulses got=%0d exp=0", load_cyc.size() + ferr_cyc.size() - n0 - f0); end
    enable = 1'b1;
    n0 = load_cyc.size();
    fork
      send_frame(8'h81, 1'b1, s);
      begin
        repeat (40) @(posedge clk);
        #2 enable = 1'b0;
      end
    join
    rx = 1'b1;
    idle(20);
    enable = 1'b1;
    total++;
    if (load_cyc.size() - n0 !== 1) begin
      bad++; $display("FAIL en_mid_count got=%0d exp=1", load_cyc.size() - n0);
    end else begin
      total++; if (load_cyc[n0] !== exp_pulse(s)) begin bad++; $display("FAIL en_mid_cycle got=%0d exp=%0d", load_cyc[n0], exp_pulse(s)); end
      total++; if (load_dat[n0] !== 8'h81) begin bad++; $display("FAIL en_mid_data got=%h exp=81", load_dat[n0]); end
    end
  endtask

  task automatic test_back_to_back();
    int s0, s1, n0;
    n0 = load_cyc.size();
    send_frame(8'hFF, 1'b1, s0);
    send_frame(8'h00, 1'b1, s1);
    rx = 1'b1;
    idle(20);
    total++;
    if (load_cyc.size() - n0 !== 2) begin
      bad++; $display("FAIL b2b_count got=%0d exp=2", load_cyc.size() - n0);
    end else begin
      total++; if (load_cyc[n0 + 1] - load_cyc[n0] !== 10 * CPB) begin bad++; $display("FAIL b2b_spacing got=%0d exp=%0d", load_cyc[n0 + 1] - load_cyc[n0], 10 * CPB); end
      total++; if (load_cyc[n0] !== exp_pulse(s0)) begin bad++; $display("FAIL b2b_first_cycle got=%0d exp=%0d", load_cyc[n0], exp_pulse(s0)); end
      total++; if (load_dat[n0] !== 8'hFF) begin bad++; $display("FAIL b2b_first_data got=%h exp=ff", load_dat[n0]); end
      total++; if (load_dat[n0 + 1] !== 8'h00) begin bad++; $display("FAIL b2b_second_data got=%h exp=00", load_dat[n0 + 1]); end
    end
  endtask

  task automatic test_random();
    int           s, g, n0, f0;
    int           exp_lc[$];
    logic [W-1:0] exp_ld[$];
    int           exp_fc[$];
    logic [W-1:0] b;
    logic         stop;
    n0 = load_cyc.size(); f0 = ferr_cyc.size();
    for (int k = 0; k < 20; k++) begin
      b    = W'($urandom);
      stop = ($urandom_range(0, 3) != 0);
      send_frame(b, stop, s);
      if (stop) begin
        exp_lc.push_back(exp_pulse(s));
        exp_ld.push_back(b);
        g = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 40));
      end else begin
        exp_fc.push_back(exp_pulse(s));
        g = int'($urandom_range(2 * CPB, 3 * CPB));
      end
      rx = 1'b1;
      if (g > 0) idle(g);
    end
    idle(3 * CPB);
    total++;
    if (load_cyc.size() - n0 !== exp_lc.size()) begin
      bad++; $display("FAIL rand_load_count got=%0d exp=%0d", load_cyc.size() - n0, exp_lc.size());
    end else begin
      for (int i = 0; i < exp_lc.size(); i++) begin
        total++; if (load_cyc[n0 + i] !== exp_lc[i]) begin bad++; $display("FAIL rand_load_cycle[%0d] got=%0d exp=%0d", i, load_cyc[n0 + i], exp_lc[i]); end
        total++; if (load_dat[n0 + i] !== exp_ld[i]) begin bad++; $display("FAIL rand_load_data[%0d] got=%h exp=%h", i, load_dat[n0 + i], exp_ld[i]); end
      end
      if (exp_ld.size() > 0) begin
        total++; if (data_out !== exp_ld[exp_ld.size() - 1]) begin bad++; $display("FAIL rand_hold got=%h exp=%h", data_out, exp_ld[exp_ld.size() - 1]); end
      end
    end
    total++;
    if (ferr_cyc.size() - f0 !== exp_fc.size()) begin
      bad++; $display("FAIL rand_ferr_count got=%0d exp=%0d", ferr_cyc.size() - f0, exp_fc.size());
    end else begin
      for (int i = 0; i < exp_fc.size(); i++) begin
        total++; if (ferr_cyc[f0 + i] !== exp_fc[i]) begin bad++; $display("FAIL rand_ferr_cycle[%0d] got=%0d exp=%0d", i, ferr_cyc[f0 + i], exp_fc[i]); end
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int s, b0, p0;
    send_frame(8'h5A, 1'b1, s);
    rx = 1'b1;
    idle(20);
    total++; if (data_out !== 8'h5A) begin bad++; $display("FAIL rst_pre_data got=%h exp=5a", data_out); end
    rx = 1'b0;
    s  = cyc;
    idle(CPB);
    rx = 1'b1;
    while (cyc < s + 40) idle(1);
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL rst_pre_busy got=%b exp=1", busy); end
    #2 async_nreset = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_async_busy got=%b exp=0", busy); end
    total++; if (load !== 1'b0) begin bad++; $display("FAIL rst_async_load got=%b exp=0", load); end
    total++; if (frame_error !== 1'b0) begin bad++; $display("FAIL rst_async_ferr got=%b exp=0", frame_error); end
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL rst_async_data got=%h exp=00", data_out); end
    idle(2);
    async_nreset = 1'b1;
    b0 = busy_cnt; p0 = load_cyc.size() + ferr_cyc.size();
    idle(12 * CPB);
    total++; if (busy_cnt - b0 !== 0) begin bad++; $display("FAIL rst_after_busy got=%0d exp=0", busy_cnt - b0); end
    total++; if (load_cyc.size() + ferr_cyc.size() - p0 !== 0) begin bad++; $display("FAIL rst_after_pulses got=%0d exp=0", load_cyc.size() + ferr_cyc.size() - p0); end
    total++; if (data_out !== 8'h00) begin bad++; $display("FAIL rst_after_data got=%h exp=00", data_out); end
  endtask

  task automatic test_pulse_rules();
    total++; if (rule_viol !== 0) begin bad++; $display("FAIL pulse_rules got=%0d exp=0", rule_viol); end
  endtask

  initial begin
    async_nreset = 1'b0;
    rx           = 1'b1;
    enable       = 1'b0;
    repeat (3) @(posedge clk);
    #1 async_nreset = 1'b1;
    test_reset();
    test_good_frame();
    test_frame_error();
    test_glitch();
    test_enable();
    test_back_to_back();
    test_random();
    test_reset_mid_frame();
    test_pulse_rules();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/serial_loader.md
# serial_loader

Asynchronous serial receiver that deserializes start/data/stop frames from a single line and hands each completed word to a downstream load/increment register through its parallel data input and load strobe. It is the stage directly upstream of that register: `data_out` feeds the register's data input, and `load` feeds its load input. The block oversamples the line with the system clock, validates each frame's start and stop bits, and reports framing errors without disturbing the last good word.

## Interface
- `WIDTH`, 8: data bits per frame and width of `data_out`.
- `CLKS_PER_BIT`, 16: clock cycles per serial bit; even, ≥ 4. Counter width is ceil(log2(CLKS_PER_BIT)).

Ports:
- `clk`  in  1  system clock; all state changes on the rising edge.
- `async_nreset`  in  1  reset; asynchronous and active-low.
- `rx`  in  1  serial line, asynchronous to `clk`, idle high.
- `enable`  in  1  when high, start-bit detection is permitted; when low, a frame is never begun.
- `data_out`  out  WIDTH  last correctly framed word, held until the next good frame.
- `load`  out  1  one-cycle pulse; `data_out` is new in the same cycle.
- `frame_error`  out  1  one-cycle pulse when the stop bit is sampled low.
- `busy`  out  1  high whenever state ≠ IDLE.

## Operation
- Synchronizer: two flops on `rx`, both reset to 1; `rx_s` = second flop. The FSM uses only `rx_s`.
- FSM states: IDLE, START, DATA, STOP. Internal state: a bit counter (0..CLKS_PER_BIT-1), a bit index (0..WIDTH-1), and a WIDTH-bit shift register.
- IDLE: if `enable`=1 and `rx_s`=0, go to START and clear the bit counter. Otherwise stay.
- START: count up. When count = CLKS_PER_BIT/2-1 (start-bit midpoint):
  - if `rx_s`=0, go to DATA and clear the counter and bit index;
  - if `rx_s`=1, treat it as a glitch and return to IDLE with no pulse.
- DATA: count up. When count = CLKS_PER_BIT-1:
  - shift `rx_s` in at the MSB (shift right, so the frame is LSB first) and clear the counter;
  - after the WIDTH-th sample, go to STOP; otherwise increment the bit index.
- STOP: count up. When count = CLKS_PER_BIT-1, sample `rx_s` and go to IDLE.
  - `rx_s`=1: `data_out` ← shift register, and `load` pulses.
  - `rx_s`=0: `frame_error` pulses, and `data_out` is unchanged.
- `enable` gates only the IDLE→START transition. Deasserting it mid-frame does not abort the frame.
- `load` and `frame_error` are registered and never high in the same cycle. Neither is ever high for two consecutive cycles.
- Back-to-back frames: IDLE is re-entered right after the stop sample. A low `rx_s` in that IDLE cycle starts the next frame with no dead cycle.
- Reset (at any time, including mid-frame):
  - state IDLE, counters 0, shift register 0;
  - `data_out`=0, `load`=0, `frame_error`=0, `busy`=0, synchronizer flops 1;
  - a partially received frame is discarded.

## Timing
- Let T0 be the cycle in which the FSM is in IDLE and sees `rx_s`=0 with `enable`=1. `rx_s` lags `rx` by 2 clocks.
- Sample edges, counted from T0 with H = CLKS_PER_BIT/2:
  - start midpoint: T0+H;
  - data bit i (i=0..WIDTH-1): T0+H+(i+1)·CLKS_PER_BIT;
  - stop bit: T0+H+(WIDTH+1)·CLKS_PER_BIT.
- `load` or `frame_error` is high in the cycle after the stop-sample edge. For the defaults, T0+152 is the stop sample and the pulse is in cycle T0+153.
- `busy` rises in cycle T0+1 and falls in the same cycle as the `load`/`frame_error` pulse.
- The downstream register captures `data_out` at the edge ending the `load` cycle.

## Test plan
- Reset values: assert `async_nreset`=0 mid-DATA → `busy`, `load`, `frame_error` and `data_out` are all 0 immediately, without waiting for a clock. Release reset → `rx`=1 idle produces no pulses.
- Good frame: defaults, `enable`=1, send 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first) with a valid stop bit → exactly one `load` pulse at T0+153, `data_out`=0xA5, `frame_error` never high.
- Framing error: after 0xA5 is loaded, send 0x3C with stop bit 0 → one `frame_error` pulse, no `load`, `data_out` stays 0xA5.
- Glitch rejection: drive `rx` low for 4 cycles, then high → `busy` is high for 8 cycles and then returns to 0, with no pulses.
- Enable gating: with `enable`=0, a full 0x55 frame → no `busy` and no pulses. Deassert `enable` during DATA of a 0x81 frame → the frame still completes with `load` and `data_out`=0x81.
- Back-to-back: 0xFF then 0x00 with no idle gap → two `load` pulses exactly 10·CLKS_PER_BIT = 160 cycles apart, with `data_out` = 0xFF then 0x00.
